rf_operand_seq: RTL and testbench

- Operand-fetch sequencer for the single-read-port register file (16 x 32, asynchronous read, synchronous write).
- Time-multiplexes the one read port to fetch up to two source operands (A, then B) into holding registers.
- Forwards a same-cycle write-back so that reads never return stale data.
- Hands the operand pair to the ALU-side control via a valid/ready handshake.

---
 rtl/rf_seq_pkg.sv | 17 +
 rtl/rf_operand_mux.sv | 39 +++
 rtl/rf_operand_seq.sv | 163 ++++++++++++++++
 tb/tb_rf_operand_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the operand-fetch sequencer and its register file.
//   - seq_state_e : sequencer state encoding (2-bit binary)
//   - RF_DEPTH    : default register-file address width (2^RF_DEPTH registers)
//   - RF_WIDTH    : default register-file data width
package rf_seq_pkg;

    localparam int RF_DEPTH = 4;
    localparam int RF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_A = 2'd1,
        ST_RD_B = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rf_operand_mux.sv
// Operand select on the shared read path. Picks, in priority order:
//   1. zero when base-address semantics are on and the address is 0
//   2. the write-back data landing on this same edge (forwarding)
//   3. the register-file read data
// Ports:
//   zero_r0   in  : treat address 0 as constant zero
//   addr      in  : address currently on the read port
//   rf_wr_en  in  : snooped write enable
//   rf_w_addr in  : snooped write address
//   rf_w_data in  : snooped write data
//   rf_r_data in  : register-file read data for addr
//   operand   out : selected operand value
module rf_operand_mux
    import rf_seq_pkg::*;
#(
    parameter int depth = RF_DEPTH,
    parameter int width = RF_WIDTH
) (
    input  logic             zero_r0,
    input  logic [depth-1:0] addr,
    input  logic             rf_wr_en,
    input  logic [depth-1:0] rf_w_addr,
    input  logic [width-1:0] rf_w_data,
    input  logic [width-1:0] rf_r_data,
    output logic [width-1:0] operand
);

    always_comb begin
        operand = rf_r_data;
        if (zero_r0 && (addr == '0)) begin
            operand = '0;
        end else if (rf_wr_en && (rf_w_addr == addr)) begin
            // The register file only commits this write at the coming edge,
            // so its read data is still the old value.
            operand = rf_w_data;
        end
    end

endmodule

// File: rtl/rf_operand_seq.sv
// Operand-fetch sequencer: time-multiplexes the single register-file read
// port to fetch operand A, then optionally operand B, into holding registers
// and offers them to the consumer.
// Handshake: op_valid is high exactly in HOLD; op_a/op_b are stable while
// op_valid is high; a transfer happens on a rising edge with op_valid and
// op_ready both high. A new request (start) is accepted in IDLE, or in the
// accepting HOLD cycle for back-to-back fetches; otherwise start is ignored.
// Ports:
//   clk, clr                     : clock, synchronous active-high reset
//   start, a_addr, b_addr        : fetch request and source registers
//   need_b, zero_r0              : request options
//   busy, op_valid, op_ready     : status and consumer handshake
//   op_a, op_b                   : operand holding registers
//   rf_r_addr, rf_r_data         : register-file read port
//   rf_wr_en, rf_w_addr, rf_w_data : snooped register-file write port
//   dbg_state                    : current sequencer state
module rf_operand_seq
    import rf_seq_pkg::*;
#(
    parameter int depth = RF_DEPTH,
    parameter int width = RF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [depth-1:0] a_addr,
    input  logic [depth-1:0] b_addr,
    input  logic             need_b,
    input  logic             zero_r0,
    output logic             busy,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [width-1:0] op_a,
    output logic [width-1:0] op_b,
    output logic [depth-1:0] rf_r_addr,
    input  logic [width-1:0] rf_r_data,
    input  logic             rf_wr_en,
    input  logic [depth-1:0] rf_w_addr,
    input  logic [width-1:0] rf_w_data,
    output logic [1:0]       dbg_state
);

    seq_state_e       state_q, state_d;
    logic [depth-1:0] a_addr_q, a_addr_d;
    logic [depth-1:0] b_addr_q, b_addr_d;
    logic             need_b_q, need_b_d;
    logic             zero_r0_q, zero_r0_d;
    logic [width-1:0] op_a_q, op_a_d;
    logic [width-1:0] op_b_q, op_b_d;
    logic             busy_q, busy_d;
    logic             op_valid_q, op_valid_d;
    logic [depth-1:0] rf_r_addr_q, rf_r_addr_d;
    logic [width-1:0] sel_data;

    // Read address is registered, so it always matches the read cycle's state.
    rf_operand_mux #(
        .depth(depth),
        .width(width)
    ) u_mux (
        .zero_r0  (zero_r0_q),
        .addr     (rf_r_addr_q),
        .rf_wr_en (rf_wr_en),
        .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data),
        .rf_r_data(rf_r_data),
        .operand  (sel_data)
    );

    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        need_b_d  = need_b_q;
        zero_r0_d = zero_r0_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_addr_d  = a_addr;
                    b_addr_d  = b_addr;
                    need_b_d  = need_b;
                    zero_r0_d = zero_r0;
                    state_d   = ST_RD_A;
                end
            end
            ST_RD_A: begin
                op_a_d = sel_data;
                if (need_b_q) begin
                    state_d = ST_RD_B;
                end else begin
                    op_b_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_RD_B: begin
                op_b_d  = sel_data;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (op_ready) begin
                    if (start) begin
                        // Back-to-back: skip IDLE and fetch straight away.
                        a_addr_d  = a_addr;
                        b_addr_d  = b_addr;
                        need_b_d  = need_b;
                        zero_r0_d = zero_r0;
                        state_d   = ST_RD_A;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops
        // aligned with the state they describe.
        busy_d      = (state_d != ST_IDLE);
        op_valid_d  = (state_d == ST_HOLD);
        rf_r_addr_d = '0;
        if (state_d == ST_RD_A) begin
            rf_r_addr_d = a_addr_d;
        end else if (state_d == ST_RD_B) begin
            rf_r_addr_d = b_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            need_b_q    <= 1'b0;
            zero_r0_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            busy_q      <= 1'b0;
            op_valid_q  <= 1'b0;
            rf_r_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            need_b_q    <= need_b_d;
            zero_r0_q   <= zero_r0_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            busy_q      <= busy_d;
            op_valid_q  <= op_valid_d;
            rf_r_addr_q <= rf_r_addr_d;
        end
    end

    assign busy      = busy_q;
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign rf_r_addr = rf_r_addr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_operand_seq.sv
// Bench for rf_operand_seq: a behavioural 16x32 register file drives the read
// port; expected operands are "register contents as they stand right after the
// edge that ends the operand's read cycle" (zero for R0 when zero_r0 is set).
module tb_rf_operand_seq;
    import rf_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [DEPTH-1:0] a_addr;
    logic [DEPTH-1:0] b_addr;
    logic             need_b;
    logic             zero_r0;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [DEPTH-1:0] rf_r_addr;
    logic [WIDTH-1:0] rf_r_data;
    logic             rf_wr_en;
    logic [DEPTH-1:0] rf_w_addr;
    logic [WIDTH-1:0] rf_w_data;
    logic [1:0]       dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    // Register file model: asynchronous read, synchronous write.
    logic [WIDTH-1:0] mem [2**DEPTH];
    always @(posedge clk) if (rf_wr_en) mem[rf_w_addr] <= rf_w_data;
    assign rf_r_data = mem[rf_r_addr];

    rf_operand_seq #(.depth(DEPTH), .width(WIDTH)) dut (
        .clk(clk), .clr(clr), .start(start), .a_addr(a_addr), .b_addr(b_addr),
        .need_b(need_b), .zero_r0(zero_r0), .busy(busy), .op_valid(op_valid),
        .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .rf_r_addr(rf_r_addr),
        .rf_r_data(rf_r_data), .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data), .dbg_state(dbg_state)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] b, input logic nb, input logic z);
        a_addr = a; b_addr = b; need_b = nb; zero_r0 = z; start = 1'b1;
    endtask

    task automatic rf_write(input logic [3:0] addr, input logic [31:0] data);
        rf_wr_en = 1'b1; rf_w_addr = addr; rf_w_data = data;
        tick();
        rf_wr_en = 1'b0;
    endtask

    task automatic rand_wr(input logic [3:0] a, input logic [3:0] b);
        int pick;
        rf_wr_en  = 1'($urandom_range(0, 1));
        pick      = int'($urandom_range(0, 2));
        rf_w_addr = (pick == 0) ? a : (pick == 1) ? b : 4'($urandom_range(0, 15));
        rf_w_data = $urandom;
    endtask

    task automatic check_state(input string tag, input logic [1:0] st, input logic bz,
                               input logic vl, input logic [3:0] ra);
        check({tag, "_state"}, 32'(dbg_state), 32'(st));
        check({tag, "_busy"}, 32'(busy), 32'(bz));
        check({tag, "_valid"}, 32'(op_valid), 32'(vl));
        check({tag, "_raddr"}, 32'(rf_r_addr), 32'(ra));
    endtask

    initial begin
        logic [3:0]  ra, rb;
        logic        rnb, rz;
        logic [31:0] ea, eb;
        int          hold_n;

        clr = 1'b1; start = 1'b0; a_addr = '0; b_addr = '0; need_b = 1'b0;
        zero_r0 = 1'b0; op_ready = 1'b0; rf_wr_en = 1'b0; rf_w_addr = '0; rf_w_data = '0;
        tick(); tick();
        check_state("reset", ST_IDLE, 1'b0, 1'b0, 4'd0);
        check("reset_op_a", op_a, 32'h0);
        check("reset_op_b", op_b, 32'h0);
        clr = 1'b0;

        rf_write(4'd3, 32'h11);
        rf_write(4'd5, 32'h22);
        rf_write(4'd7, 32'h0);
        rf_write(4'd0, 32'h55);

        // 1: two-operand fetch
        op_ready = 1'b1;
        request(4'd3, 4'd5, 1'b1, 1'b0);
        tick(); start = 1'b0;
        check_state("t1_rda", ST_RD_A, 1'b1, 1'b0, 4'd3);
        tick();
        check_state("t1_rdb", ST_RD_B, 1'b1, 1'b0, 4'd5);
        check("t1_op_a_early", op_a, 32'h11);
        tick();
        check_state("t1_hold", ST_HOLD, 1'b1, 1'b1, 4'd0);
        check("t1_op_a", op_a, 32'h11);
        check("t1_op_b", op_b, 32'h22);
        tick();
        check_state("t1_idle", ST_IDLE, 1'b0, 1'b0, 4'd0);

        // 2: single-operand fetch
        request(4'd5, 4'd3, 1'b0, 1'b0);
        tick(); start = 1'b0;
        check_state("t2_rda", ST_RD_A, 1'b1, 1'b0, 4'd5);
        tick();
        check_state("t2_hold", ST_HOLD, 1'b1, 1'b1, 4'd0);
        check("t2_op_a", op_a, 32'h22);
        check("t2_op_b", op_b, 32'h0);
        tick();

        // 3: forwarding during RD_A
        request(4'd7, 4'd0, 1'b0, 1'b0);
        tick(); start = 1'b0;
        rf_wr_en = 1'b1; rf_w_addr = 4'd7; rf_w_data = 32'hDEADBEEF;
        tick(); rf_wr_en = 1'b0;
        check("t3_fwd_a", op_a, 32'hDEADBEEF);
        tick();
        // write to R7 during RD_B must not disturb captured op_a
        request(4'd7, 4'd3, 1'b1, 1'b0);
        tick(); start = 1'b0;
        tick();
        rf_wr_en = 1'b1; rf_w_addr = 4'd7; rf_w_data = 32'h12345678;
        tick(); rf_wr_en = 1'b0;
        check("t3_late_wr_a", op_a, 32'hDEADBEEF);
        check("t3_late_wr_b", op_b, 32'h11);
        tick();
        // write one cycle before RD_A comes back through the register file
        request(4'd7, 4'd0, 1'b0, 1'b0);
        rf_wr_en = 1'b1; rf_w_addr = 4'd7; rf_w_data = 32'hCAFEF00D;
        tick(); start = 1'b0; rf_wr_en = 1'b0;
        tick();
        check("t3_prior_wr", op_a, 32'hCAFEF00D);
        tick();

        // 4: zero_r0 semantics
        request(4'd0, 4'd0, 1'b0, 1'b1);
        tick(); start = 1'b0; tick();
        check("t4_zero", op_a, 32'h0);
        tick();
        request(4'd0, 4'd0, 1'b0, 1'b0);
        tick(); start = 1'b0; tick();
        check("t4_r0_read", op_a, 32'h55);
        tick();
        request(4'd0, 4'd0, 1'b0, 1'b1);
        tick(); start = 1'b0;
        rf_wr_en = 1'b1; rf_w_addr = 4'd0; rf_w_data = 32'h77;
        tick(); rf_wr_en = 1'b0;
        check("t4_zero_wins", op_a, 32'h0);
        tick();
        request(4'd0, 4'd0, 1'b0, 1'b0);
        tick(); start = 1'b0;
        rf_wr_en = 1'b1; rf_w_addr = 4'd0; rf_w_data = 32'h88;
        tick(); rf_wr_en = 1'b0;
        check("t4_r0_fwd", op_a, 32'h88);
        tick();

        // 5: stall in HOLD, then back-to-back start
        op_ready = 1'b0;
        request(4'd3, 4'd5, 1'b1, 1'b0);
        tick(); start = 1'b0; tick(); tick();
        for (int i = 0; i < 4; i++) begin
            rf_wr_en = 1'b1; rf_w_addr = 4'd3; rf_w_data = 32'h99;
            tick();
            check("t5_hold_valid", 32'(op_valid), 32'h1);
            check("t5_hold_op_a", op_a, 32'h11);
        end
        rf_wr_en = 1'b0;
        op_ready = 1'b1;
        request(4'd5, 4'd0, 1'b0, 1'b0);
        tick(); start = 1'b0;
        check_state("t5_b2b", ST_RD_A, 1'b1, 1'b0, 4'd5);
        tick();
        check("t5_b2b_op_a", op_a, 32'h22);
        tick();

        // 6: clear during RD_B, with start held alongside it
        request(4'd3, 4'd5, 1'b1, 1'b0);
        tick(); tick();
        clr = 1'b1;
        tick();
        check_state("t6_clr", ST_IDLE, 1'b0, 1'b0, 4'd0);
        check("t6_op_a", op_a, 32'h0);
        check("t6_op_b", op_b, 32'h0);
        clr = 1'b0; start = 1'b0;
        tick();
        check_state("t6_after", ST_IDLE, 1'b0, 1'b0, 4'd0);

        // Randomized fetches against the register-contents model
        for (int r = 0; r < 16; r++) rf_write(4'(r), $urandom);
        for (int it = 0; it < 60; it++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rb  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rnb = 1'($urandom_range(0, 1));
            rz  = ($urandom_range(0, 3) == 0);
            request(ra, rb, rnb, rz);
            op_ready = 1'b1;
            rand_wr(ra, rb);
            tick(); start = 1'b0;
            check_state("rnd_rda", ST_RD_A, 1'b1, 1'b0, ra);
            rand_wr(ra, rb);
            tick();
            ea = (rz && ra == 4'd0) ? 32'h0 : mem[ra];
            eb = 32'h0;
            if (rnb) begin
                check_state("rnd_rdb", ST_RD_B, 1'b1, 1'b0, rb);
                check("rnd_op_a_mid", op_a, ea);
                rand_wr(ra, rb);
                tick();
                eb = (rz && rb == 4'd0) ? 32'h0 : mem[rb];
            end
            check_state("rnd_hold", ST_HOLD, 1'b1, 1'b1, 4'd0);
            check("rnd_op_a", op_a, ea);
            check("rnd_op_b", op_b, eb);
            op_ready = 1'b0;
            hold_n = int'($urandom_range(0, 3));
            for (int h = 0; h < hold_n; h++) begin
                rand_wr(ra, rb);
                tick();
                check("rnd_stall_valid", 32'(op_valid), 32'h1);
                check("rnd_stall_op_a", op_a, ea);
                check("rnd_stall_op_b", op_b, eb);
            end
            rf_wr_en = 1'b0;
            // Otherwise stay in HOLD; next iteration accepts and restarts at once.
            if (it == 59 || $urandom_range(0, 1) == 0) begin
                op_ready = 1'b1;
                tick();
                check_state("rnd_idle", ST_IDLE, 1'b0, 1'b0, 4'd0);
                op_ready = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
